screen_buffer: RTL and testbench

- Owns the 64x32 monochrome CHIP-8 framebuffer: 256 bytes in one single-port synchronous-read RAM.
- Responder side of the screen read interface (scr_read / scr_read_idx / scr_read_byte / scr_read_ack / scr_busy). The screen bridge is the initiator on that interface.
- Also executes the CPU's draw-row (XOR with collision detect) and clear-screen commands.
- Sits between cpu and screen_bridge.

---
 rtl/chip8_screen_pkg.sv | 37 +++
 rtl/screen_ram.sv | 40 ++++
 rtl/screen_buffer.sv | 237 +++++++++++++++++++++++
 tb/tb_screen_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_screen_pkg.sv
// ---------------------------------------------------------------------------
// chip8_screen_pkg
// Shared definitions for the CHIP-8 framebuffer: screen geometry, the
// framebuffer index width, the screen engine state encoding and the sprite
// row spreading helper used by the draw-row command.
// No ports (package).
// ---------------------------------------------------------------------------
package chip8_screen_pkg;

   localparam int SCREEN_W  = 64;
   localparam int SCREEN_H  = 32;
   localparam int ROW_BYTES = 8;
   localparam int FB_BYTES  = 256;
   localparam int IDX_W     = 8;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      RD_S  = 4'd1,
      ACK_S = 4'd2,
      RD_A  = 4'd3,
      WR_A  = 4'd4,
      RD_B  = 4'd5,
      WR_B  = 4'd6,
      ACK_D = 4'd7,
      CLR   = 4'd8,
      ACK_C = 4'd9
   } scr_state_e;

   // Spread a sprite row across two adjacent framebuffer bytes for a pixel
   // offset s: [15:8] is the mask for the left byte, [7:0] for the right one.
   // With s == 0 the right half is all zero.
   function automatic logic [15:0] sprite_spread(input logic [7:0] row,
                                                 input logic [2:0] s);
      return {row, 8'h00} >> s;
   endfunction

endpackage

// File: rtl/screen_ram.sv
// ---------------------------------------------------------------------------
// screen_ram
// 256x8 single-port framebuffer RAM with synchronous read, written so that
// it maps onto one iCE40 block RAM. No reset on contents or read register.
// Ports:
//   clk    system clock
//   en     access enable for this cycle
//   we     write enable (with en); a write does not update rdata
//   addr   byte index
//   wdata  write data
//   rdata  read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module screen_ram
   import chip8_screen_pkg::*;
(
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);

   logic [7:0] mem_r [0:FB_BYTES-1];
   logic [7:0] rdata_r;

   // Single access per cycle: either write the addressed byte or latch it.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_r[addr] <= wdata;
         end else begin
            rdata_r <= mem_r[addr];
         end
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/screen_buffer.sv
// ---------------------------------------------------------------------------
// screen_buffer
// Owns the 64x32 monochrome CHIP-8 framebuffer. Serves byte reads for the
// screen bridge and executes the CPU's draw-row (XOR with collision detect)
// and clear-screen commands. Request priority in IDLE: clear > draw > read.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   hold                  CPU frame lock, forces scr_busy high
//   clr_req / clr_ack     clear request (level) / done pulse
//   draw_req / draw_ack   draw-row request (level) / done pulse
//   draw_x, draw_y        pixel column 0..63, row 0..31
//   draw_byte             sprite row, bit7 = leftmost pixel
//   draw_collide          collision result, updated with each draw_ack
//   scr_busy              hold OR engine in a clear/draw state
//   scr_read / _ack       read request (level) / done pulse
//   scr_read_idx          byte index y*8 + x/8
//   scr_read_byte         read data, valid in ack cycle, held until next ack
// ---------------------------------------------------------------------------
module screen_buffer
   import chip8_screen_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             clr_req,
   output logic             clr_ack,
   input  logic             draw_req,
   input  logic [5:0]       draw_x,
   input  logic [4:0]       draw_y,
   input  logic [7:0]       draw_byte,
   output logic             draw_ack,
   output logic             draw_collide,
   output logic             scr_busy,
   input  logic             scr_read,
   input  logic [IDX_W-1:0] scr_read_idx,
   output logic [7:0]       scr_read_byte,
   output logic             scr_read_ack
);

   scr_state_e       state_r;
   logic [IDX_W-1:0] clr_idx_r;
   logic             clr_from_reset_r;
   logic [IDX_W-1:0] a_idx_r;
   logic [IDX_W-1:0] b_idx_r;
   logic [7:0]       mask_a_r;
   logic [7:0]       mask_b_r;
   logic             unaligned_r;
   logic [IDX_W-1:0] read_idx_r;
   logic             coll_a_r;
   logic             draw_collide_r;
   logic             draw_ack_r;
   logic             clr_ack_r;
   logic             scr_read_ack_r;
   logic [7:0]       read_hold_r;

   logic             ram_en_s;
   logic             ram_we_s;
   logic [IDX_W-1:0] ram_addr_s;
   logic [7:0]       ram_wdata_s;
   logic [7:0]       ram_rdata_s;
   logic [15:0]      spread_s;
   logic [2:0]       col_b_s;
   logic             engine_busy_s;

   screen_ram u_ram (
      .clk   (clk),
      .en    (ram_en_s),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   assign spread_s = sprite_spread(draw_byte, draw_x[2:0]);
   // Right-hand byte wraps to column 0 of the same row.
   assign col_b_s  = draw_x[5:3] + 3'd1;

   // RAM port steering: one access per state, data read in the previous state.
   always_comb begin
      ram_en_s    = 1'b0;
      ram_we_s    = 1'b0;
      ram_addr_s  = 8'h00;
      ram_wdata_s = 8'h00;
      case (state_r)
         RD_S: begin
            ram_en_s   = 1'b1;
            ram_addr_s = read_idx_r;
         end
         RD_A: begin
            ram_en_s   = 1'b1;
            ram_addr_s = a_idx_r;
         end
         WR_A: begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = a_idx_r;
            ram_wdata_s = ram_rdata_s ^ mask_a_r;
         end
         RD_B: begin
            ram_en_s   = 1'b1;
            ram_addr_s = b_idx_r;
         end
         WR_B: begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = b_idx_r;
            ram_wdata_s = ram_rdata_s ^ mask_b_r;
         end
         CLR: begin
            ram_en_s   = 1'b1;
            ram_we_s   = 1'b1;
            ram_addr_s = clr_idx_r;
         end
         default: begin
            ram_en_s = 1'b0;
         end
      endcase
   end

   // Screen engine: request arbitration, draw/clear sequencing, acks.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_idx_r      <= 8'h00;
         a_idx_r        <= 8'h00;
         b_idx_r        <= 8'h00;
         mask_a_r       <= 8'h00;
         mask_b_r       <= 8'h00;
         unaligned_r    <= 1'b0;
         read_idx_r     <= 8'h00;
         coll_a_r       <= 1'b0;
         draw_collide_r <= 1'b0;
         draw_ack_r     <= 1'b0;
         clr_ack_r      <= 1'b0;
         scr_read_ack_r <= 1'b0;
         read_hold_r    <= 8'h00;
         if (CLEAR_ON_RESET) begin
            state_r          <= CLR;
            clr_from_reset_r <= 1'b1;
         end else begin
            state_r          <= IDLE;
            clr_from_reset_r <= 1'b0;
         end
      end else begin
         draw_ack_r     <= 1'b0;
         clr_ack_r      <= 1'b0;
         scr_read_ack_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (clr_req) begin
                  clr_idx_r        <= 8'h00;
                  clr_from_reset_r <= 1'b0;
                  state_r          <= CLR;
               end else if (draw_req) begin
                  a_idx_r     <= {draw_y, draw_x[5:3]};
                  b_idx_r     <= {draw_y, col_b_s};
                  mask_a_r    <= spread_s[15:8];
                  mask_b_r    <= spread_s[7:0];
                  unaligned_r <= (draw_x[2:0] != 3'd0);
                  state_r     <= RD_A;
               end else if (scr_read) begin
                  read_idx_r <= scr_read_idx;
                  state_r    <= RD_S;
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_S: begin
               scr_read_ack_r <= 1'b1;
               state_r        <= ACK_S;
            end
            ACK_S: begin
               read_hold_r <= ram_rdata_s;
               state_r     <= IDLE;
            end
            RD_A: begin
               state_r <= WR_A;
            end
            WR_A: begin
               coll_a_r <= |(ram_rdata_s & mask_a_r);
               if (unaligned_r) begin
                  state_r <= RD_B;
               end else begin
                  draw_collide_r <= |(ram_rdata_s & mask_a_r);
                  draw_ack_r     <= 1'b1;
                  state_r        <= ACK_D;
               end
            end
            RD_B: begin
               state_r <= WR_B;
            end
            WR_B: begin
               draw_collide_r <= coll_a_r | (|(ram_rdata_s & mask_b_r));
               draw_ack_r     <= 1'b1;
               state_r        <= ACK_D;
            end
            ACK_D: begin
               state_r <= IDLE;
            end
            CLR: begin
               clr_idx_r <= clr_idx_r + 8'd1;
               if (clr_idx_r == 8'hFF) begin
                  // A power-up clear has no requester, so it ends silently.
                  if (clr_from_reset_r) begin
                     clr_from_reset_r <= 1'b0;
                     state_r          <= IDLE;
                  end else begin
                     clr_ack_r <= 1'b1;
                     state_r   <= ACK_C;
                  end
               end else begin
                  state_r <= CLR;
               end
            end
            ACK_C: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign engine_busy_s = !(state_r inside {IDLE, RD_S, ACK_S});

   assign scr_busy      = hold | engine_busy_s;
   assign clr_ack       = clr_ack_r;
   assign draw_ack      = draw_ack_r;
   assign draw_collide  = draw_collide_r;
   assign scr_read_ack  = scr_read_ack_r;
   // RAM data only arrives in the ack cycle; the holding register keeps it
   // stable afterwards while the RAM port is reused for other accesses.
   assign scr_read_byte = (state_r == ACK_S) ? ram_rdata_s : read_hold_r;

endmodule

// File: tb/tb_screen_buffer.sv
module tb_screen_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       hold;
   logic       clr_req;
   logic       clr_ack;
   logic       draw_req;
   logic [5:0] draw_x;
   logic [4:0] draw_y;
   logic [7:0] draw_byte;
   logic       draw_ack;
   logic       draw_collide;
   logic       scr_busy;
   logic       scr_read;
   logic [7:0] scr_read_idx;
   logic [7:0] scr_read_byte;
   logic       scr_read_ack;

   int checks   = 0;
   int failures = 0;

   screen_buffer #(.CLEAR_ON_RESET(1'b1)) dut (
      .clk           (clk),
      .reset         (reset),
      .hold          (hold),
      .clr_req       (clr_req),
      .clr_ack       (clr_ack),
      .draw_req      (draw_req),
      .draw_x        (draw_x),
      .draw_y        (draw_y),
      .draw_byte     (draw_byte),
      .draw_ack      (draw_ack),
      .draw_collide  (draw_collide),
      .scr_busy      (scr_busy),
      .scr_read      (scr_read),
      .scr_read_idx  (scr_read_idx),
      .scr_read_byte (scr_read_byte),
      .scr_read_ack  (scr_read_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic checkn(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Read one byte: ack expected on the second edge after the request.
   task automatic do_read(input logic [7:0] idx, input logic [7:0] exp, input string tag);
      scr_read_idx = idx;
      scr_read     = 1'b1;
      tick();
      check1({tag, "_ack_early"}, scr_read_ack, 1'b0);
      scr_read_idx = ~idx;
      tick();
      check1({tag, "_ack"}, scr_read_ack, 1'b1);
      check8({tag, "_data"}, scr_read_byte, exp);
      scr_read = 1'b0;
      tick();
      check8({tag, "_held"}, scr_read_byte, exp);
   endtask

   // Draw one row; operands are scrambled after the sampling edge.
   task automatic do_draw(input logic [5:0] x, input logic [4:0] y, input logic [7:0] b,
                          input int lat, input logic exp_col, input string tag);
      draw_x    = x;
      draw_y    = y;
      draw_byte = b;
      draw_req  = 1'b1;
      for (int i = 0; i < lat - 1; i++) begin
         tick();
         if (i == 0) begin
            draw_x    = ~x;
            draw_y    = ~y;
            draw_byte = ~b;
         end
      end
      check1({tag, "_ack_early"}, draw_ack, 1'b0);
      tick();
      check1({tag, "_ack"}, draw_ack, 1'b1);
      check1({tag, "_collide"}, draw_collide, exp_col);
      draw_req = 1'b0;
      tick();
   endtask

   // Called in the first CLR cycle after reset is released.
   task automatic reset_clear(input string tag);
      int nb;
      int na;
      nb = 0;
      na = 0;
      if (scr_busy) nb++;
      if (clr_ack || draw_ack) na++;
      for (int i = 0; i < 255; i++) begin
         tick();
         if (scr_busy) nb++;
         if (clr_ack || draw_ack) na++;
      end
      checkn({tag, "_busy_cycles"}, nb, 256);
      checkn({tag, "_acks"}, na, 0);
      tick();
      check1({tag, "_busy_after"}, scr_busy, 1'b0);
      check1({tag, "_clr_ack_after"}, clr_ack, 1'b0);
   endtask

   initial begin
      int nb;
      int na;
      reset        = 1'b1;
      hold         = 1'b0;
      clr_req      = 1'b0;
      draw_req     = 1'b0;
      draw_x       = 6'd0;
      draw_y       = 5'd0;
      draw_byte    = 8'h00;
      scr_read     = 1'b0;
      scr_read_idx = 8'h00;
      repeat (3) tick();
      check1("rst_busy", scr_busy, 1'b1);
      check1("rst_clr_ack", clr_ack, 1'b0);
      check1("rst_draw_ack", draw_ack, 1'b0);
      check1("rst_read_ack", scr_read_ack, 1'b0);
      check1("rst_collide", draw_collide, 1'b0);
      check8("rst_read_byte", scr_read_byte, 8'h00);
      reset = 1'b0;
      reset_clear("rst1");

      // Fill the screen with 0xAA using aligned draws.
      for (int y = 0; y < 32; y++) begin
         for (int c = 0; c < 8; c++) begin
            do_draw(6'(c * 8), 5'(y), 8'hAA, 3, 1'b0, "fill");
         end
      end
      do_read(8'h00, 8'hAA, "fill_rd00");
      do_read(8'hFF, 8'hAA, "fill_rdff");

      // Reset over a full screen: silent clear.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      reset_clear("rst2");
      do_read(8'h00, 8'h00, "rst2_rd00");
      do_read(8'hFF, 8'h00, "rst2_rdff");

      // Aligned draw and XOR-back.
      do_draw(6'd0, 5'd0, 8'hF0, 3, 1'b0, "d1");
      do_read(8'h00, 8'hF0, "d1_rd");
      do_draw(6'd0, 5'd0, 8'hF0, 3, 1'b1, "d2");
      do_read(8'h00, 8'h00, "d2_rd");

      // Unaligned draws spanning two bytes.
      do_draw(6'd4, 5'd1, 8'hFF, 5, 1'b0, "d3");
      do_read(8'h08, 8'h0F, "d3_rd8");
      do_read(8'h09, 8'hF0, "d3_rd9");
      do_draw(6'd6, 5'd1, 8'h80, 5, 1'b1, "d4");
      do_read(8'h08, 8'h0D, "d4_rd8");
      do_read(8'h09, 8'hF0, "d4_rd9");

      // Horizontal wrap on the last row.
      do_draw(6'd60, 5'd31, 8'hFF, 5, 1'b0, "wrap");
      do_read(8'hFF, 8'h0F, "wrap_rd255");
      do_read(8'hF8, 8'hF0, "wrap_rd248");
      do_read(8'hF7, 8'h00, "wrap_rd247");

      // All three requests at once: clear, then draw, then read.
      clr_req      = 1'b1;
      draw_req     = 1'b1;
      draw_x       = 6'd10;
      draw_y       = 5'd2;
      draw_byte    = 8'hC3;
      scr_read     = 1'b1;
      scr_read_idx = 8'h11;
      tick();
      nb = 0;
      na = 0;
      if (scr_busy) nb++;
      if (clr_ack || draw_ack || scr_read_ack) na++;
      for (int i = 0; i < 255; i++) begin
         tick();
         if (scr_busy) nb++;
         if (clr_ack || draw_ack || scr_read_ack) na++;
      end
      checkn("all_clr_busy", nb, 256);
      checkn("all_clr_early_acks", na, 0);
      tick();
      check1("all_clr_ack", clr_ack, 1'b1);
      check1("all_clr_ack_busy", scr_busy, 1'b1);
      clr_req = 1'b0;
      tick();
      check1("all_idle1_busy", scr_busy, 1'b0);
      check1("all_idle1_clr_ack", clr_ack, 1'b0);
      nb = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (scr_busy) nb++;
         if (draw_ack) nb = nb + 100;
      end
      checkn("all_draw_busy", nb, 4);
      tick();
      check1("all_draw_ack", draw_ack, 1'b1);
      check1("all_draw_collide", draw_collide, 1'b0);
      draw_req = 1'b0;
      tick();
      check1("all_idle2_busy", scr_busy, 1'b0);
      check1("all_idle2_read_ack", scr_read_ack, 1'b0);
      tick();
      check1("all_rds_busy", scr_busy, 1'b0);
      check1("all_rds_ack", scr_read_ack, 1'b0);
      tick();
      check1("all_read_ack", scr_read_ack, 1'b1);
      check8("all_read_data", scr_read_byte, 8'h30);
      check1("all_acks_busy", scr_busy, 1'b0);
      scr_read = 1'b0;
      tick();
      do_read(8'h12, 8'hC0, "all_rd18");

      // Reads are served while hold keeps scr_busy high.
      hold = 1'b1;
      #1;
      check1("hold_busy", scr_busy, 1'b1);
      scr_read_idx = 8'h12;
      scr_read     = 1'b1;
      tick();
      check1("hold_rds_busy", scr_busy, 1'b1);
      tick();
      check1("hold_read_ack", scr_read_ack, 1'b1);
      check8("hold_read_data", scr_read_byte, 8'hC0);
      scr_read = 1'b0;
      tick();
      hold = 1'b0;
      #1;
      check1("hold_release_busy", scr_busy, 1'b0);

      // Reset during WR_B of an unaligned draw: no ack, clear from index 0.
      draw_x    = 6'd4;
      draw_y    = 5'd3;
      draw_byte = 8'hFF;
      draw_req  = 1'b1;
      repeat (4) tick();
      check1("abort_wrb_ack", draw_ack, 1'b0);
      check1("abort_wrb_busy", scr_busy, 1'b1);
      reset = 1'b1;
      tick();
      check1("abort_rst_ack", draw_ack, 1'b0);
      reset    = 1'b0;
      draw_req = 1'b0;
      reset_clear("rst3");
      for (int i = 0; i < 256; i++) begin
         do_read(8'(i), 8'h00, "abort_rd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
